// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with registered read data and registered full/empty/count.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module sync_fifo_core #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              push,
  input  logic              pull,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              full_q,   full_d;
  logic              empty_q,  empty_d;
  logic [DATA_W-1:0] dout_q;
  logic              wr_en, rd_en;

  // Acceptance uses the registered flags, so a push into a full FIFO is dropped
  // even when a pull frees a slot on the same edge.
  assign wr_en = push && !full_q;
  assign rd_en = pull && !empty_q;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
              (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      if (rd_en) dout_q <= mem[rd_ptr_q[ADDR_W-1:0]];
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by the pointers, which keeps it mappable to RAM.
  always_ff @(posedge sclk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= d_in;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  assign ovf_d = ovf_q || (push && full_q);
  assign unf_d = unf_q || (pull && empty_q);

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign d_out = dout_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: tb/tb_sync_fifo_core.sv
// Directed self-checking bench for sync_fifo_core (DATA_W=8, DEPTH=16).
// Flag expectations follow FIFO_ERR_FLAGS_EN when the bench is built with it.
module tb_sync_fifo_core;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              sclk = 1'b0;
  logic              rst;
  logic              push, pull;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;
  logic              full, empty;
  logic [ADDR_W:0]   count;
  logic              overflow, underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .push      (push),
    .pull      (pull),
    .d_in      (d_in),
    .d_out     (d_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cycle(input logic p, input logic q, input logic [DATA_W-1:0] d);
    push = p;
    pull = q;
    d_in = d;
    @(posedge sclk);
    #1;
    push = 1'b0;
    pull = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    push = 1'b0;
    pull = 1'b0;
    d_in = '0;
    rst  = 1'b0;

    // Reset
    repeat (3) @(posedge sclk);
    #1;
    rst = 1'b1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_dout", d_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);

    // Fill and drain
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 8'(i + 1));
      check("fill_count", count, i + 1);
    end
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 0);
      check("drain_data", d_out, i + 1);
      check("drain_count", count, 15 - i);
    end
    check("drain_empty", empty, 1);
    check("drain_full", full, 0);

    // Wrap-around
    for (int i = 0; i < 10; i++) cycle(1, 0, 8'(8'h30 + i));
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0);
      check("wrap_pre_data", d_out, 8'h30 + i);
    end
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(8'hA0 + i));
    check("wrap_full", full, 1);
    check("wrap_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 0);
      check("wrap_data", d_out, 8'hA0 + i);
    end
    check("wrap_empty", empty, 1);
    check("pre_err_ovf", overflow, 0);
    check("pre_err_unf", underflow, 0);

    // Error conditions
    cycle(0, 1, 0);
    check("unf_flag", underflow, ERR_EN);
    check("unf_count", count, 0);
    check("unf_empty", empty, 1);
    check("unf_dout", d_out, 8'hAF);
    check("unf_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(8'hC0 + i));
    cycle(1, 0, 8'hFF);
    check("ovf_flag", overflow, ERR_EN);
    check("ovf_count", count, 16);
    check("ovf_full", full, 1);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 0);
      check("ovf_data", d_out, 8'hC0 + i);
    end
    check("ovf_empty", empty, 1);
    check("sticky_ovf", overflow, ERR_EN);
    check("sticky_unf", underflow, ERR_EN);

    // Simultaneous push and pull
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h60 + i));
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 8'(8'h65 + i));
      check("sim_data", d_out, 8'h60 + i);
      check("sim_count", count, 5);
    end
    for (int i = 0; i < 11; i++) cycle(1, 0, 8'(8'h6D + i));
    check("sim_full", full, 1);
    cycle(1, 1, 8'hEE);
    check("simf_count", count, 15);
    check("simf_data", d_out, 8'h68);
    check("simf_full", full, 0);
    for (int i = 0; i < 15; i++) begin
      cycle(0, 1, 0);
      check("simf_drain", d_out, 8'h69 + i);
    end
    check("simf_empty", empty, 1);
    cycle(1, 1, 8'h99);
    check("sime_count", count, 1);
    check("sime_dout", d_out, 8'h77);
    check("sime_empty", empty, 0);
    cycle(0, 1, 0);
    check("sime_data", d_out, 8'h99);
    check("sime_empty2", empty, 1);

    // Reset mid-stream
    for (int i = 0; i < 7; i++) cycle(1, 0, 8'(8'h40 + i));
    check("mid_count7", count, 7);
    rst = 1'b0;
    @(posedge sclk);
    #1;
    rst = 1'b1;
    check("mid_count", count, 0);
    check("mid_empty", empty, 1);
    check("mid_dout", d_out, 0);
    check("mid_ovf", overflow, 0);
    check("mid_unf", underflow, 0);
    cycle(1, 0, 8'h55);
    check("mid_push_count", count, 1);
    cycle(0, 1, 0);
    check("mid_data", d_out, 8'h55);
    check("mid_empty2", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
